cosim_loopback_responder: RTL and testbench



---
 rtl/cosim_loopback_pkg.sv | 45 ++++
 rtl/cosim_loopback_fifo.sv | 59 +++++
 rtl/cosim_loopback_responder.sv | 110 +++++++++++
 tb/tb_cosim_loopback_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_loopback_pkg.sv
// Shared types, field layout and response function for the cosim loopback responder.
// Message layout: [7:0] seq, [9:8] opcode, [W-1:10] payload.
package cosim_loopback_pkg;

  localparam int SEQ_LSB     = 0;
  localparam int SEQ_BITS    = 8;
  localparam int OP_LSB      = 8;
  localparam int OP_BITS     = 2;
  localparam int PAYLOAD_LSB = 10;
  localparam int MAX_W       = 1024;

  typedef enum logic [1:0] {
    OP_ECHO   = 2'd0,
    OP_INC    = 2'd1,
    OP_INV    = 2'd2,
    OP_STATUS = 2'd3
  } opcode_e;

  typedef logic [MAX_W-1:0] word_t;

  // Computes on a wide word so any message width up to MAX_W shares one body.
  function automatic word_t loopback_compute(
    input word_t       req,
    input word_t       status_word,
    input int unsigned width
  );
    word_t mask;
    word_t hdr_mask;
    word_t pay;
    word_t res;
    mask     = (word_t'(1) << (width - PAYLOAD_LSB)) - word_t'(1);
    hdr_mask = (word_t'(1) << PAYLOAD_LSB) - word_t'(1);
    pay      = (req >> PAYLOAD_LSB) & mask;
    res      = pay;
    unique case (opcode_e'(req[OP_LSB +: OP_BITS]))
      OP_ECHO:   res = pay;
      OP_INC:    res = (pay + word_t'(1)) & mask;
      OP_INV:    res = ~pay & mask;
      OP_STATUS: res = status_word & mask;
      default:   res = pay;
    endcase
    return (res << PAYLOAD_LSB) | (req & hdr_mask);
  endfunction

endpackage

// File: rtl/cosim_loopback_fifo.sv
// Synchronous response FIFO, power-of-2 depth.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cosim_loopback_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("cosim_loopback_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so push is legal when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cosim_loopback_responder.sv
// Hardware half of cosim loopback: one stage register feeding a response FIFO,
// plus sequence checking and saturating status counters.
module cosim_loopback_responder
  import cosim_loopback_pkg::*;
#(
  parameter int TYPE_SIZE_BITS = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ReqValid,
  output logic                      ReqReady,
  input  logic [TYPE_SIZE_BITS-1:0] Req,
  output logic                      RespValid,
  input  logic                      RespReady,
  output logic [TYPE_SIZE_BITS-1:0] Resp,
  output logic [CNT_BITS-1:0]       RespCount,
  output logic [CNT_BITS-1:0]       SeqErrCount,
  output logic                      Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  if (TYPE_SIZE_BITS < 16 || TYPE_SIZE_BITS >= MAX_W) begin : g_width_chk
    $error("cosim_loopback_responder: TYPE_SIZE_BITS out of range");
  end

  logic                      stage_vld_q, stage_vld_d;
  logic [TYPE_SIZE_BITS-1:0] stage_q, stage_d;
  logic [SEQ_BITS-1:0]       exp_seq_q, exp_seq_d;
  logic [CNT_BITS-1:0]       resp_cnt_q, resp_cnt_d;
  logic [CNT_BITS-1:0]       seq_err_q, seq_err_d;
  logic                      rdy_en_q;

  logic                      accept;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [AW:0]               fifo_count;
  logic [AW:0]               occ;
  logic [SEQ_BITS-1:0]       req_seq;
  word_t                     resp_w;
  logic                      unused_bits;

  // Stage counts toward occupancy so its push next edge always fits.
  assign occ       = fifo_count + {{AW{1'b0}}, stage_vld_q};
  assign ReqReady  = rdy_en_q && (occ < DEPTH_C);
  assign accept    = ReqValid && ReqReady;
  assign RespValid = !fifo_empty;
  assign pop       = RespValid && RespReady;
  assign Busy      = stage_vld_q || !fifo_empty;
  assign req_seq   = Req[SEQ_LSB +: SEQ_BITS];

  assign RespCount   = resp_cnt_q;
  assign SeqErrCount = seq_err_q;
  assign unused_bits = ^{resp_w[MAX_W-1:TYPE_SIZE_BITS], fifo_full};

  always_comb begin
    resp_w = loopback_compute(
      word_t'(Req),
      word_t'({seq_err_q, resp_cnt_q}),
      TYPE_SIZE_BITS
    );
    stage_vld_d = accept;
    stage_d     = accept ? resp_w[TYPE_SIZE_BITS-1:0] : stage_q;
    exp_seq_d   = accept ? req_seq + 8'd1 : exp_seq_q;
    seq_err_d   = seq_err_q;
    resp_cnt_d  = resp_cnt_q;
    if (accept && req_seq != exp_seq_q && seq_err_q != '1)
      seq_err_d = seq_err_q + CNT_BITS'(1);
    if (pop && resp_cnt_q != '1)
      resp_cnt_d = resp_cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      exp_seq_q   <= '0;
      resp_cnt_q  <= '0;
      seq_err_q   <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      exp_seq_q   <= exp_seq_d;
      resp_cnt_q  <= resp_cnt_d;
      seq_err_q   <= seq_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  cosim_loopback_fifo #(
    .WIDTH (TYPE_SIZE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rstn),
    .push  (stage_vld_q),
    .pop   (pop),
    .din   (stage_q),
    .dout  (Resp),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_cosim_loopback_responder.sv
// Directed bench for cosim_loopback_responder with default parameters
// (64-bit messages, 54-bit payload, 4-deep FIFO, 16-bit counters).
module tb_cosim_loopback_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ReqValid;
  logic        ReqReady;
  logic [63:0] Req;
  logic        RespValid;
  logic        RespReady;
  logic [63:0] Resp;
  logic [15:0] RespCount;
  logic [15:0] SeqErrCount;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cosim_loopback_responder #(
    .TYPE_SIZE_BITS (64),
    .FIFO_DEPTH     (4),
    .CNT_BITS       (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .Req         (Req),
    .RespValid   (RespValid),
    .RespReady   (RespReady),
    .Resp        (Resp),
    .RespCount   (RespCount),
    .SeqErrCount (SeqErrCount),
    .Busy        (Busy)
  );

  function automatic logic [63:0] mk(
    input logic [7:0] s, input logic [1:0] op, input logic [53:0] p
  );
    return {p, op, s};
  endfunction

  task automatic do_reset();
    rstn = 1'b0; ReqValid = 1'b0; RespReady = 1'b0; Req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] r);
    bit done = 1'b0;
    ReqValid = 1'b1; Req = r;
    for (int i = 0; i < 50 && !done; i++) begin
      if (ReqReady) done = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    ReqValid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: ReqReady=0 for 50 cycles, req=%h", r);
    end
  endtask

  task automatic recv(output logic [63:0] r);
    bit ok = 1'b0;
    r = '0; RespReady = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (RespValid) begin r = Resp; ok = 1'b1; end
      @(posedge clk); @(negedge clk);
    end
    RespReady = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL recv_timeout: RespValid=0 for 50 cycles");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; ReqValid = 1'b0; RespReady = 1'b0; Req = '0;
    #12;
    checks++;
    if ({ReqReady, RespValid, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: rdy/vld/busy=%b want 000",
               {ReqReady, RespValid, Busy});
    end
    checks++;
    if (Resp !== 64'h0) begin
      errors++; $display("FAIL reset_resp: got %h want 0", Resp);
    end
    checks++;
    if ({RespCount, SeqErrCount} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: got %h/%h want 0/0", RespCount, SeqErrCount);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b want 1", ReqReady);
    end
  endtask

  task automatic test_echo();
    logic [63:0] e;
    e = mk(8'd0, 2'd0, 54'hABCDEF);
    RespReady = 1'b1; ReqValid = 1'b1; Req = e;
    @(posedge clk); @(negedge clk);
    ReqValid = 1'b0;
    checks++;
    if (RespValid !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL echo_stage: vld=%b busy=%b want 0 1", RespValid, Busy);
    end
    @(negedge clk);
    checks++;
    if (RespValid !== 1'b1 || Resp !== e) begin
      errors++;
      $display("FAIL echo_resp: vld=%b resp=%h want 1 %h", RespValid, Resp, e);
    end
    @(negedge clk);
    RespReady = 1'b0;
    checks++;
    if (RespValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL echo_drain: vld=%b busy=%b want 0 0", RespValid, Busy);
    end
    checks++;
    if (RespCount !== 16'd1 || SeqErrCount !== 16'd0) begin
      errors++;
      $display("FAIL echo_counts: got %0d/%0d want 1/0", RespCount, SeqErrCount);
    end
  endtask

  task automatic test_ops();
    logic [63:0] r;
    send(mk(8'd1, 2'd1, {54{1'b1}}));
    recv(r);
    checks++;
    if (r !== mk(8'd1, 2'd1, 54'h0)) begin
      errors++; $display("FAIL inc_wrap: got %h want %h", r, mk(8'd1, 2'd1, 54'h0));
    end
    send(mk(8'd2, 2'd2, 54'h0));
    recv(r);
    checks++;
    if (r !== mk(8'd2, 2'd2, {54{1'b1}})) begin
      errors++;
      $display("FAIL inv_zero: got %h want %h", r, mk(8'd2, 2'd2, {54{1'b1}}));
    end
    checks++;
    if (RespCount !== 16'd3 || SeqErrCount !== 16'd0) begin
      errors++;
      $display("FAIL ops_counts: got %0d/%0d want 3/0", RespCount, SeqErrCount);
    end
  endtask

  task automatic test_seq_status();
    logic [63:0] exp_q [4];
    logic [63:0] r;
    do_reset();
    exp_q[0] = mk(8'd0, 2'd0, 54'h11);
    exp_q[1] = mk(8'd5, 2'd0, 54'h22);
    exp_q[2] = mk(8'd6, 2'd0, 54'h33);
    exp_q[3] = mk(8'd7, 2'd3, 54'h10000);
    send(exp_q[0]);
    send(exp_q[1]);
    checks++;
    if (SeqErrCount !== 16'd1) begin
      errors++; $display("FAIL seq_gap: got %0d want 1", SeqErrCount);
    end
    send(exp_q[2]);
    send(mk(8'd7, 2'd3, 54'h2AAAA));
    checks++;
    if (SeqErrCount !== 16'd1 || ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL seq_resync: err=%0d rdy=%b want 1 0", SeqErrCount, ReqReady);
    end
    for (int k = 0; k < 4; k++) begin
      recv(r);
      checks++;
      if (r !== exp_q[k]) begin
        errors++; $display("FAIL status_q%0d: got %h want %h", k, r, exp_q[k]);
      end
    end
    send(mk(8'd9, 2'd3, 54'h3FF));
    checks++;
    if (SeqErrCount !== 16'd2) begin
      errors++; $display("FAIL status_err: got %0d want 2", SeqErrCount);
    end
    recv(r);
    checks++;
    if (r !== mk(8'd9, 2'd3, 54'h10004)) begin
      errors++;
      $display("FAIL status_snap: got %h want %h", r, mk(8'd9, 2'd3, 54'h10004));
    end
  endtask

  task automatic test_fill_hold();
    logic [63:0] first;
    logic [63:0] r;
    int n = 0;
    bit acc;
    bit moved = 1'b0;
    do_reset();
    first = mk(8'd0, 2'd0, 54'd100);
    ReqValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      Req = mk(8'(n), 2'd0, 54'(100 + n));
      acc = ReqReady;
      if (RespValid && Resp !== first) moved = 1'b1;
      @(posedge clk); @(negedge clk);
      if (acc) n++;
    end
    ReqValid = 1'b0;
    checks++;
    if (n != 4 || ReqReady !== 1'b0) begin
      errors++; $display("FAIL fill_accepts: got %0d rdy=%b want 4 0", n, ReqReady);
    end
    checks++;
    if (moved || RespValid !== 1'b1 || Resp !== first) begin
      errors++; $display("FAIL fill_stable: resp=%h want %h", Resp, first);
    end
    for (int k = 0; k < 4; k++) begin
      recv(r);
      checks++;
      if (r !== mk(8'(k), 2'd0, 54'(100 + k))) begin
        errors++;
        $display("FAIL drain_%0d: got %h want %h", k, r,
                 mk(8'(k), 2'd0, 54'(100 + k)));
      end
    end
    checks++;
    if (RespValid !== 1'b0 || RespCount !== 16'd4) begin
      errors++;
      $display("FAIL drain_end: vld=%b cnt=%0d want 0 4", RespValid, RespCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q [$];
    logic [63:0] r;
    int n = 0;
    int pops = 0;
    int bad = 0;
    bit acc;
    bit pv;
    do_reset();
    ReqValid = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      Req = mk(8'(n), 2'd1, 54'(1000 + n));
      acc = ReqReady;
      @(posedge clk); @(negedge clk);
      if (acc) begin q.push_back(mk(8'(n), 2'd1, 54'(1001 + n))); n++; end
    end
    RespReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      Req = mk(8'(n), 2'd1, 54'(1000 + n));
      acc = ReqReady;
      pv = RespValid;
      if (pv && (q.size() == 0 || Resp !== q[0])) begin
        bad++;
        $display("FAIL b2b_order: cycle %0d got %h", c, Resp);
      end
      @(posedge clk); @(negedge clk);
      if (pv && q.size() != 0) begin void'(q.pop_front()); pops++; end
      if (acc) begin q.push_back(mk(8'(n), 2'd1, 54'(1001 + n))); n++; end
    end
    ReqValid = 1'b0; RespReady = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (pops != 20 || n != 23 || q.size() != 3) begin
      errors++;
      $display("FAIL b2b_rate: pops=%0d acc=%0d left=%0d want 20 23 3",
               pops, n, q.size());
    end
    for (int k = 0; k < 3; k++) begin
      recv(r);
      checks++;
      if (q.size() == 0 || r !== q[0]) begin
        errors++; $display("FAIL b2b_tail_%0d: got %h", k, r);
      end
      if (q.size() != 0) void'(q.pop_front());
    end
    checks++;
    if (RespCount !== 16'd23 || SeqErrCount !== 16'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts: cnt=%0d err=%0d busy=%b want 23 0 0",
               RespCount, SeqErrCount, Busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    RespReady = 1'b0;
    send(mk(8'd200, 2'd0, 54'h5));
    send(mk(8'd201, 2'd0, 54'h6));
    send(mk(8'd202, 2'd0, 54'h7));
    @(negedge clk);
    checks++;
    if (SeqErrCount !== 16'd1 || RespCount !== 16'd23 || RespValid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: err=%0d cnt=%0d vld=%b want 1 23 1",
               SeqErrCount, RespCount, RespValid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({RespValid, Busy, ReqReady} !== 3'b000) begin
      errors++;
      $display("FAIL async_flags: vld/busy/rdy=%b want 000",
               {RespValid, Busy, ReqReady});
    end
    checks++;
    if (RespCount !== 16'd0 || SeqErrCount !== 16'd0) begin
      errors++;
      $display("FAIL async_counts: got %0d/%0d want 0/0", RespCount, SeqErrCount);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(mk(8'd0, 2'd0, 54'h77));
    recv(r);
    checks++;
    if (r !== mk(8'd0, 2'd0, 54'h77)) begin
      errors++; $display("FAIL post_reset_resp: got %h", r);
    end
    checks++;
    if (SeqErrCount !== 16'd0 || RespCount !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_counts: got %0d/%0d want 0/1",
               SeqErrCount, RespCount);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_ops();
    test_seq_status();
    test_fill_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
